// File: rtl/odelay_tap_ctrl_if.sv
// Tap-load request channel for odelay_tap_ctrl.
// master = calibration/CSR side, slave = controller.
interface odelay_tap_ctrl_if #(
  parameter int LANE_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic [LANE_W-1:0] req_lane;
  logic [4:0]        req_tap;

  modport master (
    output req_valid,
    output req_lane,
    output req_tap,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_lane,
    input  req_tap,
    output req_ready
  );
endinterface

// File: rtl/odelay_tap_ctrl.sv
// ODELAYE2 VAR_LOAD tap sequencer: load, settle, read back, commit.
// Define ODELAY_TAP_STEP_EN to walk taps one step per load round.
module odelay_tap_ctrl #(
  parameter int NLANES        = 4,
  parameter int LANE_W        = 2,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  odelay_tap_ctrl_if.slave    req,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [5*NLANES-1:0] tap_cur,
  output logic [4:0]          odly_cntvaluein,
  output logic [NLANES-1:0]   odly_ld,
  input  logic [5*NLANES-1:0] odly_cntvalueout
);

  localparam int LIX = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam int CW  = (SETTLE_CYCLES > 1) ?
                       $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    VERIFY,
    ERR,
    DONE
  } state_t;

  state_t            state;
  logic [LIX-1:0]    lane_q;
  logic [4:0]        cv_q;
  logic [CW-1:0]     cnt;
  logic [NLANES-1:0] ld_q;
  logic [4:0]        tap_q [NLANES];
  logic [4:0]        cvo   [NLANES];

  logic              accept;
  logic              lane_ok;
  logic [LIX-1:0]    rl;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    assign tap_cur[5*i +: 5] = tap_q[i];
    assign cvo[i] = odly_cntvalueout[5*i +: 5];
  end

  assign rl       = req.req_lane[LIX-1:0];
  assign lane_ok  = 32'(req.req_lane) < 32'(NLANES);
  assign req.req_ready = ~rst &
                         ((state == IDLE) | (state == DONE));
  assign accept   = req.req_valid & req.req_ready;
  assign busy     = (state != IDLE);
  // LD must never reach the primitives while reset is held
  assign odly_ld  = ld_q & ~{NLANES{rst}};
  assign odly_cntvaluein = cv_q;

`ifdef ODELAY_TAP_STEP_EN
  logic [4:0] tgt_q;
  logic [4:0] cur_req;

  assign cur_req = tap_q[rl];

  function automatic logic [4:0] step_to(
    input logic [4:0] from,
    input logic [4:0] to
  );
    return (to > from) ? from + 5'd1 : from - 5'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lane_q <= '0;
      cv_q   <= '0;
      cnt    <= '0;
      ld_q   <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < NLANES; i++) begin
        tap_q[i] <= '0;
      end
`ifdef ODELAY_TAP_STEP_EN
      tgt_q  <= '0;
`endif
    end else begin
      ld_q <= '0;
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (accept) begin
            err    <= 1'b0;
            lane_q <= rl;
            if (!lane_ok) begin
              state <= ERR;
            end else begin
`ifdef ODELAY_TAP_STEP_EN
              tgt_q <= req.req_tap;
              if (req.req_tap == cur_req) begin
                cv_q  <= cur_req;
                state <= VERIFY;
              end else begin
                cv_q  <= step_to(cur_req, req.req_tap);
                ld_q  <= NLANES'(1) << rl;
                state <= LOAD;
              end
`else
              cv_q  <= req.req_tap;
              ld_q  <= NLANES'(1) << rl;
              state <= LOAD;
`endif
            end
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          cnt   <= CW'(SETTLE_CYCLES - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= VERIFY;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        VERIFY: begin
          if (cvo[lane_q] == cv_q) begin
            tap_q[lane_q] <= cv_q;
`ifdef ODELAY_TAP_STEP_EN
            if (cv_q != tgt_q) begin
              cv_q  <= step_to(cv_q, tgt_q);
              ld_q  <= NLANES'(1) << lane_q;
              state <= LOAD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end else begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        ERR: begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
